load_store_unit: RTL

Data-side memory interface between the single-cycle core datapath and a word-wide data bus with variable latency. It takes the datapath's memory address and store data, builds byte strobes and lane-replicated write data, and returns sign- or zero-extended load data on the datapath's read-data input. It stalls the core while a bus transaction is outstanding and reports misaligned accesses and bus timeouts.

---
 rtl/core_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_extend.sv | 26 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - funct3 load/store encodings, LSU state type and access-size helpers
package core_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   function automatic logic is_byte(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_BU);
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return (f3 == F3_H) || (f3 == F3_HU);
   endfunction

   // Unknown funct3 codes fall through to word alignment rules.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      if (is_byte(f3))
         return 1'b0;
      else if (is_half(f3))
         return a[0];
      else
         return a != 2'b00;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data bus between the LSU and memory
interface load_store_unit_if;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_ready, bus_ack, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_ready, bus_ack, bus_rdata
   );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - picks the byte/half lane of a bus word and sign/zero extends it
module load_extend
   import core_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[{addr, 3'b000} +: 8];
      half_lane = addr[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   data = {24'b0, byte_lane};
         F3_H:    data = {{16{half_lane[15]}}, half_lane};
         F3_HU:   data = {16'b0, half_lane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core data-side memory interface: stalls the core across one
// variable-latency bus transaction, builds store strobes and returns extended load data.
module load_store_unit
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        load_data,
   output logic               stall,
   output logic               misalign,
   output logic               bus_err,
   load_store_unit_if.master  bus
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_t    state, state_next;
   logic [CW-1:0] cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [2:0]    f3_q;
   logic [3:0]    wstrb_q;
   logic [31:0]   wdata_q;
   logic [31:0]   load_q;

   logic          access, mis, start, busy, got_ack, timeout;
   logic [3:0]    strb_next;
   logic [31:0]   wdata_next;
   logic [31:0]   ext_data;

   load_extend u_extend (
      .word   (bus.bus_rdata),
      .addr   (addr_q[1:0]),
      .funct3 (f3_q),
      .data   (ext_data)
   );

   always_comb begin
      access  = mem_read | mem_write;
      mis     = is_misaligned(funct3, addr[1:0]);
      start   = (state == IDLE) && access && !mis;
      busy    = (state == REQ) || (state == WAIT);
      // An ack that lands in the last counted cycle beats the timeout.
      got_ack = ((state == REQ) && bus.bus_ready && bus.bus_ack) ||
                ((state == WAIT) && bus.bus_ack);
      timeout = busy && (cnt == CNT_LAST) && !got_ack;
   end

   always_comb begin
      strb_next  = 4'b1111;
      wdata_next = wdata;
      if (is_byte(funct3)) begin
         strb_next  = 4'b0001 << addr[1:0];
         wdata_next = {4{wdata[7:0]}};
      end else if (is_half(funct3)) begin
         strb_next  = addr[1] ? 4'b1100 : 4'b0011;
         wdata_next = {2{wdata[15:0]}};
      end
      if (!mem_write)
         strb_next = 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // DONE returns to IDLE regardless of inputs so the held instruction cannot re-issue.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = REQ;
         REQ: begin
            if (got_ack || timeout)
               state_next = DONE;
            else if (bus.bus_ready)
               state_next = WAIT;
         end
         WAIT: if (got_ack || timeout) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         f3_q    <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
         load_q  <= '0;
      end else begin
         if (start) begin
            cnt     <= '0;
            we_q    <= mem_write;
            addr_q  <= addr;
            f3_q    <= funct3;
            wstrb_q <= strb_next;
            wdata_q <= wdata_next;
         end else if (busy) begin
            cnt <= cnt + 1'b1;
         end
         if (got_ack && !we_q)
            load_q <= ext_data;
         else if (timeout)
            load_q <= '0;
      end
   end

   // Reset gating keeps the combinational outputs low while reset is held.
   always_comb begin
      stall         = reset && (start || busy);
      misalign      = reset && (state == IDLE) && access && mis;
      bus_err       = timeout;
      load_data     = load_q;
      bus.bus_valid = (state == REQ);
      bus.bus_we    = we_q;
      bus.bus_addr  = {addr_q[31:2], 2'b00};
      bus.bus_wstrb = wstrb_q;
      bus.bus_wdata = wdata_q;
   end

endmodule
